instr_stats: RTL and testbench

Parametrised instruction-mix and cycle statistics unit for the MIPS single-cycle CPU. It taps the opcode field of each retired instruction, classifies it into one of six classes, and keeps per-class event counters plus a free-running cycle counter. Counters use a configurable width with saturate or wrap behaviour and per-counter sticky overflow flags. A snapshot/readout port lets the debug or trace logic sample all counters atomically without stopping the core.

---
 rtl/instr_stats_pkg.sv | 38 +++
 rtl/stat_counter.sv | 37 +++
 rtl/instr_stats.sv | 74 +++++++
 tb/tb_instr_stats.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/instr_stats_pkg.sv
// Shared constants for the instruction-mix statistics unit: counter indices
// and the MIPS opcodes that select each instruction class.
package instr_stats_pkg;

  // Counter index order; also the rd_sel encoding and the ovf bit order.
  typedef enum logic [2:0] {
    CLS_R      = 3'd0,
    CLS_I      = 3'd1,
    CLS_J      = 3'd2,
    CLS_LOAD   = 3'd3,
    CLS_STORE  = 3'd4,
    CLS_BRANCH = 3'd5,
    CLS_CYCLE  = 3'd6
  } cnt_idx_e;

  localparam int NUM_CLS = 6;
  localparam int NUM_CNT = 7;

  localparam logic [2:0] RD_SEL_NONE = 3'd7;

  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;
  localparam logic [5:0] OP_LB     = 6'h20;
  localparam logic [5:0] OP_LH     = 6'h21;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_LBU    = 6'h24;
  localparam logic [5:0] OP_LHU    = 6'h25;
  localparam logic [5:0] OP_SB     = 6'h28;
  localparam logic [5:0] OP_SH     = 6'h29;
  localparam logic [5:0] OP_SW     = 6'h2B;

endpackage

// File: rtl/stat_counter.sv
// One event counter with selectable saturate/wrap behaviour and a sticky
// overflow flag that records any increment attempted at all-ones.
module stat_counter #(
  parameter int CNT_W    = 16,
  parameter int SATURATE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] value,
  output logic             ovf
);

  logic at_max;
  assign at_max = &value;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values, independent of the order blocks are evaluated in.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value <= '0;
      ovf   <= 1'b0;
    end else if (clr) begin
      value <= '0;
      ovf   <= 1'b0;
    end else if (inc) begin
      if (at_max) begin
        ovf   <= 1'b1;
        value <= (SATURATE != 0) ? value : '0;
      end else begin
        value <= value + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/instr_stats.sv
// Instruction-mix and cycle statistics: classifies each retired opcode,
// counts per class plus cycles, and offers an atomic snapshot readout.
module instr_stats
  import instr_stats_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int SATURATE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid,
  input  logic [5:0]       op,
  input  logic             clear,
  input  logic             snap,
  input  logic [2:0]       rd_sel,
  output logic [CNT_W-1:0] rd_data,
  output logic [6:0]       ovf
);

  logic [NUM_CLS-1:0] cls_vec;
  logic [NUM_CNT-1:0] cnt_inc;
  logic [CNT_W-1:0]   live   [NUM_CNT];
  logic [CNT_W-1:0]   shadow [NUM_CNT];

  // NOTE: combinational outputs get a default before the case so no path
  // leaves them unassigned, which would otherwise infer a latch.
  always_comb begin
    cls_vec = '0;
    if (valid) begin
      case (op)
        OP_RTYPE:                                cls_vec[CLS_R]      = 1'b1;
        OP_J, OP_JAL:                            cls_vec[CLS_J]      = 1'b1;
        OP_REGIMM, OP_BEQ, OP_BNE,
        OP_BLEZ, OP_BGTZ:                        cls_vec[CLS_BRANCH] = 1'b1;
        OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU:     cls_vec[CLS_LOAD]   = 1'b1;
        OP_SB, OP_SH, OP_SW:                     cls_vec[CLS_STORE]  = 1'b1;
        default:                                 cls_vec[CLS_I]      = 1'b1;
      endcase
    end
  end

  // The cycle counter is the top entry and counts every non-reset edge.
  assign cnt_inc = {1'b1, cls_vec};

  for (genvar i = 0; i < NUM_CNT; i++) begin : g_cnt
    stat_counter #(
      .CNT_W    (CNT_W),
      .SATURATE (SATURATE)
    ) u_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (cnt_inc[i]),
      .clr   (clear),
      .value (live[i]),
      .ovf   (ovf[i])
    );
  end

  // NOTE: the shadow array is reset explicitly because readout must be zero
  // after reset; storage arrays are otherwise usually left unreset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CNT; i++) shadow[i] <= '0;
    end else if (snap) begin
      for (int i = 0; i < NUM_CNT; i++) shadow[i] <= live[i];
    end
  end

  always_comb begin
    rd_data = '0;
    if (rd_sel != RD_SEL_NONE) rd_data = shadow[rd_sel];
  end

endmodule

// File: tb/tb_instr_stats.sv
// Bench for instr_stats: three instances (16-bit saturating, 4-bit saturating,
// 4-bit wrapping) share stimulus and are checked against a true-count model.
module tb_instr_stats;

  logic        clk;
  logic        reset;
  logic        valid;
  logic [5:0]  op;
  logic        clear;
  logic        snap;
  logic [2:0]  rd_sel;
  logic [15:0] rd_16;
  logic [3:0]  rd_s4, rd_w4;
  logic [6:0]  ovf_16, ovf_s4, ovf_w4;

  int vectors     = 0;
  int miscompares = 0;
  int rot         = 0;

  instr_stats #(.CNT_W(16), .SATURATE(1)) u_d16 (
    .clk(clk), .reset(reset), .valid(valid), .op(op), .clear(clear),
    .snap(snap), .rd_sel(rd_sel), .rd_data(rd_16), .ovf(ovf_16));
  instr_stats #(.CNT_W(4), .SATURATE(1)) u_s4 (
    .clk(clk), .reset(reset), .valid(valid), .op(op), .clear(clear),
    .snap(snap), .rd_sel(rd_sel), .rd_data(rd_s4), .ovf(ovf_s4));
  instr_stats #(.CNT_W(4), .SATURATE(0)) u_w4 (
    .clk(clk), .reset(reset), .valid(valid), .op(op), .clear(clear),
    .snap(snap), .rd_sel(rd_sel), .rd_data(rd_w4), .ovf(ovf_w4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: unbounded event counts since the last clear/reset, plus the
  // unbounded counts captured at the last snap. Each DUT width/mode is
  // derived from these by plain arithmetic.
  longint live_t [7];
  longint shad_t [7];

  function automatic int model_cls(input logic [5:0] o);
    if (o == 6'h00)                                   return 0;
    if (o inside {6'h02, 6'h03})                      return 2;
    if (o inside {6'h01, 6'h04, 6'h05, 6'h06, 6'h07}) return 5;
    if (o inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25}) return 3;
    if (o inside {6'h28, 6'h29, 6'h2B})               return 4;
    return 1;
  endfunction

  function automatic longint view(input longint t, input int w, input bit sat);
    longint mx;
    mx = (64'sd1 <<< w) - 1;
    if (sat) return (t > mx) ? mx : t;
    return t % (mx + 1);
  endfunction

  function automatic longint exp_rd(input int w, input bit sat);
    if (rd_sel == 3'd7) return 0;
    return view(shad_t[rd_sel], w, sat);
  endfunction

  function automatic longint exp_ovf(input int w);
    longint r;
    r = 0;
    for (int i = 0; i < 7; i++)
      if (live_t[i] > ((64'sd1 <<< w) - 1)) r = r | (64'sd1 <<< i);
    return r;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 7; i++) begin
        live_t[i] = 0;
        shad_t[i] = 0;
      end
    end else begin
      if (snap) for (int i = 0; i < 7; i++) shad_t[i] = live_t[i];
      if (clear) begin
        for (int i = 0; i < 7; i++) live_t[i] = 0;
      end else begin
        if (valid) live_t[model_cls(op)] = live_t[model_cls(op)] + 1;
        live_t[6] = live_t[6] + 1;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("rd16",  {48'd0, rd_16}, exp_rd(16, 1'b1));
    check("rd_s4", {60'd0, rd_s4}, exp_rd(4, 1'b1));
    check("rd_w4", {60'd0, rd_w4}, exp_rd(4, 1'b0));
    check("ovf16", {57'd0, ovf_16}, exp_ovf(16));
    check("ovf_s4", {57'd0, ovf_s4}, exp_ovf(4));
    check("ovf_w4", {57'd0, ovf_w4}, exp_ovf(4));
  end

  // One clock of stimulus; returns 1 time unit after the edge.
  task automatic cyc(input bit v, input logic [5:0] o, input bit c, input bit s);
    valid  = v;
    op     = o;
    clear  = c;
    snap   = s;
    rd_sel = 3'(rot);
    rot++;
    @(posedge clk);
    #1;
  endtask

  task automatic set_sel(input logic [2:0] s);
    rd_sel = s;
    #1;
  endtask

  logic [15:0] cyc_a, cyc_b;
  logic [5:0]  ops1 [6];

  initial begin
    reset = 1'b1; valid = 1'b0; op = '0; clear = 1'b0; snap = 1'b0; rd_sel = '0;
    ops1[0] = 6'h00; ops1[1] = 6'h23; ops1[2] = 6'h2B;
    ops1[3] = 6'h04; ops1[4] = 6'h02; ops1[5] = 6'h08;
    #2;
    check("reset_ovf", {57'd0, ovf_16}, 64'd0);
    check("reset_rd",  {48'd0, rd_16},  64'd0);
    #21;
    reset = 1'b0;

    // One op of each class, then snapshot.
    for (int i = 0; i < 6; i++) cyc(1'b1, ops1[i], 1'b0, 1'b0);
    cyc(1'b0, 6'h00, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      set_sel(3'(i));
      check($sformatf("mix_cls%0d", i), {48'd0, rd_16}, 64'd1);
    end
    set_sel(3'd6);
    check("mix_cycle", {48'd0, rd_16}, 64'd6);
    check("mix_ovf", {57'd0, ovf_16}, 64'd0);

    // Saturation / wrap of the R counter.
    cyc(1'b0, 6'h00, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) cyc(1'b1, 6'h00, 1'b0, 1'b0);
    cyc(1'b0, 6'h00, 1'b0, 1'b1);
    set_sel(3'd0);
    check("sat_r",     {60'd0, rd_s4}, 64'd15);
    check("wrap_r",    {60'd0, rd_w4}, 64'd4);
    check("sat_ovf",   {57'd0, ovf_s4}, 64'h41);
    set_sel(3'd7);
    check("sel7_zero", {48'd0, rd_16}, 64'd0);

    // Wrap of the LOAD counter.
    cyc(1'b0, 6'h00, 1'b1, 1'b0);
    for (int i = 0; i < 17; i++) cyc(1'b1, 6'h20, 1'b0, 1'b0);
    cyc(1'b0, 6'h00, 1'b0, 1'b1);
    set_sel(3'd3);
    check("wrap_load",     {60'd0, rd_w4}, 64'd1);
    check("sat_load",      {60'd0, rd_s4}, 64'd15);
    check("wrap_load_ovf", {57'd0, ovf_w4}, 64'h48);

    // Snap and clear together with a same-cycle STORE.
    cyc(1'b0, 6'h00, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b1, 6'h2B, 1'b0, 1'b0);
    cyc(1'b1, 6'h2B, 1'b1, 1'b1);
    set_sel(3'd4);
    check("snapclr_store", {48'd0, rd_16}, 64'd5);
    check("snapclr_ovf",   {57'd0, ovf_s4}, 64'd0);
    cyc(1'b0, 6'h00, 1'b0, 1'b1);
    set_sel(3'd4);
    check("after_clr_store", {48'd0, rd_16}, 64'd0);
    set_sel(3'd6);
    check("after_clr_cycle", {48'd0, rd_16}, 64'd0);

    // Idle cycles: no class counts, cycle advances by 10.
    cyc(1'b0, 6'h00, 1'b1, 1'b0);
    cyc(1'b0, 6'h00, 1'b0, 1'b1);
    set_sel(3'd6);
    cyc_a = rd_16;
    for (int i = 0; i < 9; i++) cyc(1'b0, 6'h00, 1'b0, 1'b0);
    cyc(1'b0, 6'h00, 1'b0, 1'b1);
    set_sel(3'd6);
    cyc_b = rd_16;
    check("idle_cycle_delta", {48'd0, cyc_b - cyc_a}, 64'd10);
    set_sel(3'd0);
    check("idle_r", {48'd0, rd_16}, 64'd0);

    // Asynchronous reset mid-stream.
    cyc(1'b0, 6'h00, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) cyc(1'b1, 6'h00, 1'b0, 1'b0);
    cyc(1'b0, 6'h00, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) cyc(1'b0, 6'h00, 1'b0, 1'b0);
    set_sel(3'd0);
    check("pre_rst_r",   {48'd0, rd_16}, 64'd7);
    check("pre_rst_ovf", {57'd0, ovf_s4}, 64'h40);
    #2;
    reset = 1'b1;
    #1;
    check("rst_rd16", {48'd0, rd_16}, 64'd0);
    check("rst_ovf",  {57'd0, ovf_s4}, 64'd0);
    set_sel(3'd6);
    check("rst_cycle", {48'd0, rd_16}, 64'd0);
    #2;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) cyc(1'b1, 6'h00, 1'b0, 1'b0);
    cyc(1'b0, 6'h00, 1'b0, 1'b1);
    set_sel(3'd0);
    check("post_rst_r", {48'd0, rd_16}, 64'd3);
    set_sel(3'd6);
    check("post_rst_cycle", {48'd0, rd_16}, 64'd3);

    // A few mixed ops with rotating readout for the continuous compare.
    for (int i = 0; i < 24; i++)
      cyc(1'b1, 6'(i * 5), 1'b0, (i % 4) == 3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
